osd_trace_depacketization: RTL and testbench
============================================

Name: osd_trace_depacketization

Overview:
- Receive end of the trace-event protocol. Consumes a DII flit stream carrying trace-event packets addressed to this node and rebuilds the original WIDTH-bit trace samples or overflow notifications.
- Presents each result on a valid/ready sample port.
- Sits on the host-side debug endpoint or in-fabric trace sinks, behind the debug ring interface.

Parameters:
- WIDTH, 34: trace sample width in bits. Payload word count NW = ceil(WIDTH/16), which is 3 at the default.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted while 0, sampled on posedge clk)
- id  in  10  this node's DII address; match requires dest == {6'b0, id}
- debug_in  in  dii_flit  incoming flit: valid, last, data[15:0]
- debug_in_ready  out  1  flit accept
- sample_data  out  WIDTH  reconstructed sample
- sample_src  out  16  source address of the packet
- sample_overflow  out  1  1 = overflow notification, 0 = normal sample
- sample_lost  out  16  lost-sample count; valid only when sample_overflow=1
- sample_valid  out  1  output valid
- sample_ready  in  1  output accept
- err_count  out  16  malformed-packet counter (see Optional Feature)

Behaviour:
- A flit is accepted when debug_in.valid && debug_in_ready.

Packet format:
- Flit 0: dest.
- Flit 1: src.
- Flit 2: flags. Bits [15:14] are TYPE, with 2'b10 = EVENT. Bits [13:10] are TYPE_SUB, with 0 = sample and 1 = overflow.
- Sample payload: NW words, least-significant word first. Word k maps to bits [16k+15:16k]. Bits of the top word above WIDTH are discarded.
- Overflow payload: exactly 1 word, the lost count.

State machine:
- DEST: accept flit. If last is set, go to DEST (no error). Otherwise, if data == {6'b0,id}, go to SRC; else go to DROP.
- SRC: latch src. If last is set, count an error and go to DEST; else go to FLAGS.
- FLAGS:
  - TYPE != EVENT or TYPE_SUB > 1: go to DROP (count an error), or to DEST if last.
  - Last set here: count an error, go to DEST.
  - Otherwise load the word counter with 0 and go to PAYLOAD.
- PAYLOAD: store the word at index cnt and increment cnt.
  - When the final expected word (NW-1 for sample, 0 for overflow) arrives with last set: go to OUTPUT.
  - Final word without last: go to TAIL.
  - Last set before the final word: count an error, discard, go to DEST.
- TAIL: accept and ignore flits until last, then count one error and go to OUTPUT. The sample is still delivered.
- DROP: accept flits until last, then go to DEST.
- OUTPUT: sample_valid=1 and all outputs held stable. On sample_ready go to DEST.

Handshake and timing:
- debug_in_ready=1 in every state except OUTPUT, where it is 0. The output register is not overwritten while pending.
- Latency: sample_valid rises on the cycle after the last payload flit is accepted.
- sample_valid never drops without sample_ready.
- Back-to-back packets: the first flit of the next packet can be accepted the cycle after the OUTPUT handshake.
- Assembly buffer words are cleared on entry to PAYLOAD, so a short previous packet leaves no stale data.

Reset (rst=0):
- State = DEST.
- sample_valid=0, debug_in_ready=0 during reset.
- sample_data, sample_src, sample_overflow, sample_lost all 0.
- err_count=0.
- A reset mid-packet or mid-OUTPUT discards the partial or pending sample. The remaining flits of that packet are then parsed from DEST and are treated like any other received flits (typically dropped by address mismatch).

Optional Feature:
- Macro: OSD_TRACE_DEPACK_ERRCNT_EN.
- When defined: err_count increments by 1 per counted error, saturates at 16'hFFFF, and is cleared only by reset.
- When undefined: counter logic is omitted and err_count is constant 0. Parsing and drop behaviour are otherwise identical.

Test Plan:
- id=10'h005; packet {0005, 0003, 8000, 1234, 5678, 0003(last)} -> one output with sample_data=34'h3_5678_1234, sample_src=0003, sample_overflow=0, sample_valid the cycle after last.
- Overflow packet {0005, 0007, 8400, 0042(last)} -> sample_overflow=1, sample_lost=0042, sample_src=0007.
- Packet to dest 0006 (5 flits), then a valid packet to 0005 -> only the second produces output; err_count=0.
- Hold sample_ready=0 for 10 cycles after a sample, while the next packet is presented -> debug_in_ready=0, outputs stable; after the handshake the second sample arrives intact.
- Truncated packet {0005, 0003, 8000, 1111(last)} -> no output, err_count=1 (macro on) / 0 (macro off). A following good packet decodes correctly.
- rst=0 asserted after flit 3 of a sample packet, released, then a full packet sent -> no output from the aborted packet, the new packet decoded, err_count=0.

Source files
------------

// File: rtl/osd_trace_depacketization.sv
// Trace-event depacketizer: rebuilds WIDTH-bit samples/overflow notices from DII flits.
// Define OSD_TRACE_DEPACK_ERRCNT_EN to enable the saturating malformed-packet counter.
package osd_trace_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module osd_trace_depacketization
    import osd_trace_pkg::*;
#(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       id,
    input  dii_flit          debug_in,
    output logic             debug_in_ready,
    output logic [WIDTH-1:0] sample_data,
    output logic [15:0]      sample_src,
    output logic             sample_overflow,
    output logic [15:0]      sample_lost,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [15:0]      err_count
);

    localparam int NW = (WIDTH + 15) / 16;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [2:0] {
        S_DEST,
        S_SRC,
        S_FLAGS,
        S_PAYLOAD,
        S_TAIL,
        S_DROP,
        S_OUTPUT
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NW*16-1:0]   buf_q, buf_d;
    logic [15:0]        src_q, src_d;
    logic [15:0]        lost_q, lost_d;
    logic               ovf_q, ovf_d;
    logic               err_inc;
    logic               acc;
    logic               final_w;
    logic               bad_type;

    assign debug_in_ready = rst && (state_q != S_OUTPUT);
    assign sample_valid   = rst && (state_q == S_OUTPUT);
    assign acc            = debug_in.valid && debug_in_ready;

    assign final_w  = ovf_q ? (cnt_q == '0) : (cnt_q == CW'(NW - 1));
    assign bad_type = (debug_in.data[15:14] != 2'b10) ||
                      (debug_in.data[13:10] > 4'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        src_d   = src_q;
        lost_d  = lost_q;
        ovf_d   = ovf_q;
        err_inc = 1'b0;
        unique case (state_q)
            S_DEST: begin
                if (acc && !debug_in.last) begin
                    if (debug_in.data == {6'b0, id}) state_d = S_SRC;
                    else                             state_d = S_DROP;
                end
            end
            S_SRC: begin
                if (acc) begin
                    src_d = debug_in.data;
                    if (debug_in.last) begin
                        err_inc = 1'b1;
                        state_d = S_DEST;
                    end else begin
                        state_d = S_FLAGS;
                    end
                end
            end
            S_FLAGS: begin
                if (acc) begin
                    if (bad_type || debug_in.last) begin
                        err_inc = 1'b1;
                        state_d = debug_in.last ? S_DEST : S_DROP;
                    end else begin
                        // clear assembly so a short packet cannot leak old words
                        ovf_d   = debug_in.data[10];
                        cnt_d   = '0;
                        buf_d   = '0;
                        lost_d  = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (ovf_q) begin
                        lost_d = debug_in.data;
                    end else begin
                        for (int k = 0; k < NW; k++) begin
                            if (cnt_q == CW'(k)) buf_d[16*k +: 16] = debug_in.data;
                        end
                    end
                    if (final_w) begin
                        state_d = debug_in.last ? S_OUTPUT : S_TAIL;
                    end else if (debug_in.last) begin
                        err_inc = 1'b1;
                        state_d = S_DEST;
                    end
                end
            end
            S_TAIL: begin
                if (acc && debug_in.last) begin
                    err_inc = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
            S_DROP: begin
                if (acc && debug_in.last) state_d = S_DEST;
            end
            S_OUTPUT: begin
                if (sample_ready) state_d = S_DEST;
            end
            default: state_d = S_DEST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_DEST;
            cnt_q   <= '0;
            buf_q   <= '0;
            src_q   <= '0;
            lost_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            src_q   <= src_d;
            lost_q  <= lost_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sample_data     = buf_q[WIDTH-1:0];
    assign sample_src      = src_q;
    assign sample_overflow = ovf_q;
    assign sample_lost     = lost_q;

    logic unused_pad;
    assign unused_pad = ^buf_q;

`ifdef OSD_TRACE_DEPACK_ERRCNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= '0;
        end else if (err_inc && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err;
    assign unused_err = err_inc;
    assign err_count  = '0;
`endif

endmodule

// File: tb/tb_osd_trace_depacketization.sv
// Directed self-checking bench for osd_trace_depacketization.
// Each task drives one scenario and checks its own expectations inline.
module tb_osd_trace_depacketization;
    import osd_trace_pkg::*;

`ifdef OSD_TRACE_DEPACK_ERRCNT_EN
    localparam int ERRS = 1;
`else
    localparam int ERRS = 0;
`endif

    logic        clk;
    logic        rst;
    logic [9:0]  id;
    dii_flit     debug_in;
    logic        debug_in_ready;
    logic [33:0] sample_data;
    logic [15:0] sample_src;
    logic        sample_overflow;
    logic [15:0] sample_lost;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] err_count;

    int tests;
    int fails;
    logic [15:0] pkt [8];

    osd_trace_depacketization #(.WIDTH(34)) dut (
        .clk(clk),
        .rst(rst),
        .id(id),
        .debug_in(debug_in),
        .debug_in_ready(debug_in_ready),
        .sample_data(sample_data),
        .sample_src(sample_src),
        .sample_overflow(sample_overflow),
        .sample_lost(sample_lost),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input int n, input bit end_last);
        for (int i = 0; i < n; i++) begin
            int t;
            @(negedge clk);
            debug_in.valid = 1'b1;
            debug_in.last  = end_last && (i == n - 1);
            debug_in.data  = pkt[i];
            t = 0;
            while (!debug_in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            tests++;
            if (t >= 50) begin
                fails++;
                $display("FAIL send_timeout: ready=%0b required=1", debug_in_ready);
            end
            @(posedge clk);
            #1 debug_in.valid = 1'b0;
            debug_in.last = 1'b0;
        end
    endtask

    task automatic expect_sample(input string nm, input logic [33:0] d,
                                 input logic [15:0] s, input logic o,
                                 input logic [15:0] l, input bit hs);
        @(negedge clk);
        tests++;
        if (sample_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_valid: got %0b required 1", nm, sample_valid);
        end
        tests++;
        if (!o && sample_data !== d) begin
            fails++;
            $display("FAIL %s_data: got %h required %h", nm, sample_data, d);
        end
        tests++;
        if (sample_src !== s) begin
            fails++;
            $display("FAIL %s_src: got %h required %h", nm, sample_src, s);
        end
        tests++;
        if (sample_overflow !== o) begin
            fails++;
            $display("FAIL %s_ovf: got %0b required %0b", nm, sample_overflow, o);
        end
        tests++;
        if (o && sample_lost !== l) begin
            fails++;
            $display("FAIL %s_lost: got %h required %h", nm, sample_lost, l);
        end
        if (hs) begin
            sample_ready = 1'b1;
            @(posedge clk);
            #1 sample_ready = 1'b0;
            tests++;
            if (sample_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s_hs: valid=%0b required 0", nm, sample_valid);
            end
        end
    endtask

    task automatic expect_idle(input string nm, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sample_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_idle: valid seen %0d cycles required 0", nm, bad);
        end
    endtask

    task automatic check_err(input string nm, input int e);
        tests++;
        if (err_count !== 16'(e)) begin
            fails++;
            $display("FAIL %s_err: got %0d required %0d", nm, err_count, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (sample_valid !== 1'b0 || debug_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: valid=%0b ready=%0b required 0 0",
                     sample_valid, debug_in_ready);
        end
        tests++;
        if (sample_data !== '0 || sample_src !== '0 ||
            sample_overflow !== 1'b0 || sample_lost !== '0) begin
            fails++;
            $display("FAIL reset_out: data=%h src=%h ovf=%0b lost=%h required 0",
                     sample_data, sample_src, sample_overflow, sample_lost);
        end
        check_err("reset", 0);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (debug_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: ready=%0b required 1", debug_in_ready);
        end
    endtask

    task automatic test_sample();
        pkt = '{16'h0005, 16'h0003, 16'h8000, 16'h1234,
                16'h5678, 16'h0003, 16'h0, 16'h0};
        send(6, 1'b1);
        expect_sample("sample", 34'h3_5678_1234, 16'h0003, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_overflow();
        pkt = '{16'h0005, 16'h0007, 16'h8400, 16'h0042,
                16'h0, 16'h0, 16'h0, 16'h0};
        send(4, 1'b1);
        expect_sample("ovf", 34'h0, 16'h0007, 1'b1, 16'h0042, 1'b1);
    endtask

    task automatic test_mismatch();
        pkt = '{16'h0006, 16'h0003, 16'h8000, 16'haaaa,
                16'hbbbb, 16'h0, 16'h0, 16'h0};
        send(5, 1'b1);
        expect_idle("mismatch", 4);
        pkt = '{16'h0005, 16'h0004, 16'h8000, 16'hc001,
                16'hc002, 16'h0001, 16'h0, 16'h0};
        send(6, 1'b1);
        expect_sample("mm_good", 34'h1_c002_c001, 16'h0004, 1'b0, 16'h0, 1'b1);
        check_err("mismatch", 0);
    endtask

    task automatic test_back_to_back();
        logic [33:0] held;
        pkt = '{16'h0005, 16'h0009, 16'h8000, 16'habcd,
                16'hef01, 16'h0002, 16'h0, 16'h0};
        send(6, 1'b1);
        expect_sample("bp_a", 34'h2_ef01_abcd, 16'h0009, 1'b0, 16'h0, 1'b0);
        held = 34'h2_ef01_abcd;
        pkt = '{16'h0005, 16'h000a, 16'h8000, 16'h0001,
                16'h0002, 16'h0001, 16'h0, 16'h0};
        fork
            send(6, 1'b1);
            begin
                int bad;
                bad = 0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (debug_in_ready !== 1'b0 || sample_valid !== 1'b1 ||
                        sample_data !== held || sample_src !== 16'h0009) bad++;
                end
                tests++;
                if (bad != 0) begin
                    fails++;
                    $display("FAIL bp_hold: unstable %0d cycles required 0", bad);
                end
                sample_ready = 1'b1;
                @(posedge clk);
                #1 sample_ready = 1'b0;
            end
        join
        expect_sample("bp_b", 34'h1_0002_0001, 16'h000a, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_truncated();
        pkt = '{16'h0005, 16'h0003, 16'h8000, 16'h1111,
                16'h0, 16'h0, 16'h0, 16'h0};
        send(4, 1'b1);
        expect_idle("trunc", 4);
        check_err("trunc", ERRS);
        pkt = '{16'h0005, 16'h0003, 16'h8000, 16'h2222,
                16'h3333, 16'h0000, 16'h0, 16'h0};
        send(6, 1'b1);
        expect_sample("trunc_good", 34'h0_3333_2222, 16'h0003, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_tail();
        pkt = '{16'h0005, 16'h000b, 16'h8000, 16'h0011,
                16'h0022, 16'h0002, 16'hffff, 16'h0};
        send(7, 1'b1);
        expect_sample("tail", 34'h2_0022_0011, 16'h000b, 1'b0, 16'h0, 1'b1);
        check_err("tail", 2 * ERRS);
    endtask

    task automatic test_bad_type();
        pkt = '{16'h0005, 16'h0003, 16'h4000, 16'h0001,
                16'h0002, 16'h0, 16'h0, 16'h0};
        send(5, 1'b1);
        expect_idle("badtype", 4);
        check_err("badtype", 3 * ERRS);
    endtask

    task automatic test_mid_reset();
        pkt = '{16'h0005, 16'h0003, 16'h8000, 16'h4444,
                16'h0, 16'h0, 16'h0, 16'h0};
        send(4, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        expect_idle("midrst", 3);
        check_err("midrst", 0);
        pkt = '{16'h0005, 16'h000c, 16'h8000, 16'h5555,
                16'h6666, 16'h0003, 16'h0, 16'h0};
        send(6, 1'b1);
        expect_sample("midrst_new", 34'h3_6666_5555, 16'h000c, 1'b0, 16'h0, 1'b1);
        check_err("midrst_end", 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        id = 10'h005;
        debug_in.valid = 1'b0;
        debug_in.last = 1'b0;
        debug_in.data = '0;
        sample_ready = 1'b0;
        test_reset();
        test_sample();
        test_overflow();
        test_mismatch();
        test_back_to_back();
        test_truncated();
        test_tail();
        test_bad_type();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
